// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Holds the state encoding, the count width and the default NOP fill word.
package imem_loader_pkg;

  localparam int CNT_W = 16;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR0 = 3'd1,
    S_HDR1 = 3'd2,
    S_WORD = 3'd3,
    S_CSUM = 3'd4,
    S_FILL = 3'd5,
    S_DONE = 3'd6,
    S_ERR  = 3'd7
  } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles four accepted bytes into one little-endian 32-bit word.
// word_valid is a combinational pulse on the byte that completes a word.
module imem_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx;
  logic [23:0] acc;

  // Bytes enter at the top, so after three bytes acc holds {b2, b1, b0}.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= 2'd0;
      acc <= 24'd0;
    end else if (clear) begin
      idx <= 2'd0;
      acc <= 24'd0;
    end else if (byte_valid) begin
      idx <= idx + 2'd1;
      acc <= {byte_data, acc[23:8]};
    end
  end

  assign word_valid = byte_valid && (idx == 2'd3);
  assign word       = {byte_data, acc};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a counted image into imem, pads with NOP, then releases the CPU.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the image.
module imem_loader #(
  parameter int          DEPTH    = 128,
  parameter int          ADDR_W   = 7,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);
  import imem_loader_pkg::*;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W:0]  DEPTH_A = (ADDR_W+1)'(DEPTH);

  state_t             state, next_state;
  logic [7:0]         cnt_lo;
  logic [CNT_W-1:0]   n_words, word_cnt, hdr_n;
  logic [ADDR_W:0]    fill_addr, fill_d;
  logic               we_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [31:0]        wdata_d;
  logic               accept, word_valid, last_word;
  logic [31:0]        word;

  // Handshake: a byte moves on a rising edge where in_valid && in_ready;
  // in_ready depends only on state, and in_valid may be held without effect.
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  assign in_ready = (state == S_HDR0) || (state == S_HDR1) || (state == S_WORD) ||
                    (state == S_CSUM);
`else
  assign in_ready = (state == S_HDR0) || (state == S_HDR1) || (state == S_WORD);
`endif

  assign accept    = in_valid && in_ready;
  assign hdr_n     = {in_data, cnt_lo};
  assign last_word = (word_cnt == n_words - CNT_W'(1));
  assign dbg_state = state;

  imem_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (state != S_WORD),
    .byte_valid (accept && (state == S_WORD)),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // Every transition into FILL already issues a write, and FILL leaves for DONE
  // only once fill_addr passes the end, so DONE lands the cycle after the last write.
  always_comb begin
    next_state = state;
    we_d       = 1'b0;
    addr_d     = imem_addr;
    wdata_d    = imem_wdata;
    fill_d     = fill_addr;
    case (state)
      S_IDLE: next_state = S_HDR0;
      S_HDR0: if (accept) next_state = S_HDR1;
      S_HDR1: begin
        if (accept) begin
          if (hdr_n > DEPTH_C) begin
            next_state = S_ERR;
          end else if (hdr_n == '0) begin
            next_state = S_FILL;
            we_d       = 1'b1;
            addr_d     = '0;
            wdata_d    = NOP_WORD;
            fill_d     = (ADDR_W+1)'(1);
          end else begin
            next_state = S_WORD;
          end
        end
      end
      S_WORD: begin
        if (word_valid) begin
          we_d    = 1'b1;
          addr_d  = word_cnt[ADDR_W-1:0];
          wdata_d = word;
          if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            next_state = S_CSUM;
`else
            next_state = S_FILL;
            fill_d     = n_words[ADDR_W:0];
`endif
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          if (in_data != csum) begin
            next_state = S_ERR;
          end else if (n_words == DEPTH_C) begin
            next_state = S_DONE;
          end else begin
            next_state = S_FILL;
            we_d       = 1'b1;
            addr_d     = n_words[ADDR_W-1:0];
            wdata_d    = NOP_WORD;
            fill_d     = n_words[ADDR_W:0] + (ADDR_W+1)'(1);
          end
        end
      end
`endif
      S_FILL: begin
        if (fill_addr < DEPTH_A) begin
          we_d    = 1'b1;
          addr_d  = fill_addr[ADDR_W-1:0];
          wdata_d = NOP_WORD;
          fill_d  = fill_addr + (ADDR_W+1)'(1);
        end else begin
          next_state = S_DONE;
        end
      end
      S_DONE, S_ERR: if (reload) next_state = S_HDR0;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      fill_addr  <= '0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= next_state;
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      fill_addr  <= fill_d;
      cpu_rst    <= (next_state != S_DONE);
      done       <= (next_state == S_DONE);
      err        <= (next_state == S_ERR);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_lo   <= '0;
      n_words  <= '0;
      word_cnt <= '0;
    end else begin
      if (state == S_HDR0 && accept) cnt_lo <= in_data;
      if (state == S_HDR1 && accept) n_words <= hdr_n;
      if (state == S_HDR0) word_cnt <= '0;
      else if (word_valid) word_cnt <= word_cnt + CNT_W'(1);
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum <= '0;
    end else if (state == S_HDR0) begin
      csum <= '0;
    end else if (state == S_WORD && accept) begin
      csum <= csum ^ in_data;
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader with DEPTH = 70.
// Expected imem writes are queued by the driver side and popped by a separate monitor.
module tb_imem_loader;

  localparam int          DEPTH  = 70;
  localparam int          ADDR_W = 7;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] W0     = 32'h00A0_0093;
  localparam logic [31:0] W1     = 32'h0030_0113;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              reload = 1'b0;
  logic              in_ready, imem_we, cpu_rst, done, err;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [2:0]        dbg_state;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;
  logic done_prev = 1'b0;
  logic [ADDR_W+31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int a, input logic [31:0] d);
    exp_q.push_back({ADDR_W'(a), d});
  endtask

  task automatic expect_image(input int n, input logic [31:0] w0, input logic [31:0] w1);
    if (n > 0) push_exp(0, w0);
    if (n > 1) push_exp(1, w1);
    for (int i = n; i < DEPTH; i++) push_exp(i, NOP);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [ADDR_W+31:0] e;
    cyc++;
    if (rst && imem_we) begin
      wr_count++;
      if (imem_addr == ADDR_W'(DEPTH - 1)) last_wr_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0d data %h, expected no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          errors++;
          $display("FAIL write: got addr %0d data %h expected addr %0d data %h",
                   imem_addr, imem_wdata, e[ADDR_W+31:32], e[31:0]);
        end
      end
    end
    if (done && !done_prev) done_cyc = cyc;
    done_prev = done;
  end

  // drivers
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    t = 0;
    if (gaps) begin
      int n;
      n = $urandom_range(0, 3);
      repeat (n) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom_range(0, 255));
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: in_ready stayed %b, required 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic send_stream(input int n, input logic [31:0] w0, input logic [31:0] w1,
                             input bit gaps);
    logic [15:0] cnt;
    logic [31:0] w;
    logic [7:0]  x;
    cnt = 16'(n);
    x   = 8'h00;
    send_byte(cnt[7:0], gaps);
    send_byte(cnt[15:8], gaps);
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? w0 : w1;
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8], gaps);
        x = x ^ w[8*k +: 8];
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (n > 0) send_byte(x, gaps);
`endif
    in_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    wr_count = 0;
    check("reload_cpu_rst", cpu_rst, 1);
    check("reload_done", done, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"}, imem_we, 0);
    check({tag, "_addr"}, imem_addr, 0);
    check({tag, "_wdata"}, imem_wdata, 0);
    check({tag, "_cpu_rst"}, cpu_rst, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_in_ready"}, in_ready, 0);
  endtask

  task automatic check_done(input string tag);
    int t;
    t = 0;
    while (!done && !err && t < 500) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check({tag, "_done"}, done, 1);
    check({tag, "_err"}, err, 0);
    check({tag, "_cpu_rst"}, cpu_rst, 0);
    check({tag, "_done_lag"}, 32'(done_cyc - last_wr_cyc), 1);
    check({tag, "_wr_count"}, 32'(wr_count), 32'(DEPTH));
    check({tag, "_queue_left"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;

    // basic load, valid held high
    expect_image(2, W0, W1);
    send_stream(2, W0, W1, 1'b0);
    check_done("basic");

    // same image with random valid gaps
    pulse_reload();
    expect_image(2, W0, W1);
    send_stream(2, W0, W1, 1'b1);
    check_done("gaps");

    // zero count
    pulse_reload();
    expect_image(0, W0, W1);
    send_stream(0, W0, W1, 1'b0);
    check_done("zero");

    // over-count aborts right after the header
    pulse_reload();
    send_byte(8'd71, 1'b0);
    send_byte(8'd0, 1'b0);
    in_valid = 1'b0;
    check("over_err", err, 1);
    check("over_cpu_rst", cpu_rst, 1);
    check("over_in_ready", in_ready, 0);
    repeat (5) @(negedge clk);
    check("over_no_writes", 32'(wr_count), 0);
    pulse_reload();
    expect_image(2, W0, W1);
    send_stream(2, W0, W1, 1'b0);
    check_done("after_err");

    // reset in the middle of word 0
    pulse_reload();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h93, 1'b0);
    send_byte(8'h00, 1'b0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_vals("midword_reset");
    @(negedge clk);
    rst = 1'b1;
    check("midword_no_writes", 32'(wr_count), 0);
    wr_count = 0;
    expect_image(2, W0, W1);
    send_stream(2, W0, W1, 1'b0);
    check_done("after_reset");

`ifdef IMEM_LOADER_CHECKSUM_EN
    // checksum match: 0x93 ^ 0xA0 = 0x33
    pulse_reload();
    expect_image(1, W0, W1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h93, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hA0, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h33, 1'b0);
    in_valid = 1'b0;
    check_done("csum_ok");

    // checksum mismatch keeps the written word, no fill
    pulse_reload();
    push_exp(0, W0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h93, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hA0, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h34, 1'b0);
    in_valid = 1'b0;
    check("csum_bad_err", err, 1);
    check("csum_bad_cpu_rst", cpu_rst, 1);
    repeat (5) @(negedge clk);
    check("csum_bad_writes", 32'(wr_count), 1);
    check("csum_bad_queue_left", 32'(exp_q.size()), 0);
`endif

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the CPU instruction memory; replaces the bench-side hierarchical preload of imem with synthesizable hardware.
- Accepts a byte stream (valid/ready), assembles little-endian 32-bit instructions, writes them to imem word addresses 0..N-1, then fills the remaining addresses with NOP.
- Holds the CPU in reset until the image is complete; sits between the external boot byte source and cpu_top's imem write port and reset input.

Parameters:
- DEPTH, 128, number of imem words.
- ADDR_W, 7, imem word-address width; must satisfy 2**ADDR_W >= DEPTH.
- NOP_WORD, 32'h00000013, fill value (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte-source valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte.
- reload  in  1  single-cycle pulse: restart the load from DONE or ERR.
- imem_we  out  1  imem write strobe.
- imem_addr  out  ADDR_W  imem word address.
- imem_wdata  out  32  imem write data.
- cpu_rst  out  1  active-high reset to cpu_top.
- done  out  1  image loaded; CPU released.
- err  out  1  load aborted.

Behaviour:
- Stream format: CNT_LO, CNT_HI (16-bit word count N, little-endian), then N×4 instruction bytes, each word LSB first.
- A byte is accepted on a rising edge when in_valid && in_ready.
- States:
  - IDLE: reset state; moves to HDR0 on the first clock after reset release.
  - HDR0: accepts CNT_LO, goes to HDR1.
  - HDR1: accepts CNT_HI. If N > DEPTH, go to ERR. If N == 0, go to FILL at addr 0. Otherwise go to WORD.
  - WORD: 2-bit byte index 0..3; the byte at index k goes to bits [8k+7:8k]. On acceptance of index 3, the word is complete and the word counter increments. After word N, go to FILL, or to DONE if N == DEPTH.
  - FILL: writes NOP_WORD to one address per cycle from N to DEPTH-1, then goes to DONE.
  - DONE: holds; reload returns to HDR0.
  - ERR: holds; reload returns to HDR0.
- in_ready is a combinational decode of the state: 1 only in HDR0, HDR1 and WORD. It is 0 in IDLE, FILL, DONE and ERR.
- Write timing: imem_we, imem_addr and imem_wdata are registered. imem_we pulses for exactly one cycle, in the cycle after the 4th byte handshake, with addr = word index.
- In FILL, imem_we is high every cycle.
- At most one write per cycle; addresses are strictly increasing; no address is written twice per load.
- cpu_rst is 1 in every state except DONE. It deasserts on the edge entering DONE, which is the cycle after the last write.
- done = (state == DONE) and err = (state == ERR), both registered.
- reload is ignored outside DONE and ERR. Taking reload reasserts cpu_rst on the next edge.
- in_valid held with in_ready = 0 is not a violation; the byte is simply not consumed.
- Reset values (asserted at any time, including mid-word or mid-FILL): state IDLE, counters 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_rst 1, done 0, err 0, in_ready 0.
- A partially assembled word is discarded on reset; it is never written.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined: one trailing byte follows the last instruction byte (state CSUM, in_ready = 1). It must equal the XOR of all N×4 instruction bytes. On a match, go to FILL/DONE as above; on a mismatch, go to ERR with cpu_rst held at 1. Already-written words remain in imem.
- Not defined: no CSUM state and no XOR register; the stream ends after the last instruction byte.

Decomposition:
- Package imem_loader_pkg holds:
  - the state encoding (IDLE, HDR0, HDR1, WORD, CSUM, FILL, DONE, ERR);
  - NOP_WORD;
  - the count width (16).
- One natural sub-module, imem_word_packer:
  - contents: byte index counter plus the 32-bit shift/assembly register;
  - outputs: word_valid pulse and the assembled word;
  - control: clear input driven by the FSM.

Test Plan:
- Basic load:
  - Stimulus: DEPTH = 70; stream 02 00 93 00 A0 00 13 01 30 00 with in_valid held high.
  - Required: writes addr 0 = 0x00A00093 and addr 1 = 0x00300113; addr 2..69 = 0x00000013; done = 1 and cpu_rst = 0 one cycle after the addr-69 write; exactly 70 imem_we pulses.
- Backpressure and gaps: same stream with in_valid toggled randomly → identical write sequence; no byte lost or duplicated.
- Zero count: stream 00 00 → 70 NOP writes from addr 0; done = 1.
- Over-count: N = 71 with DEPTH = 70 → err = 1 right after HDR1; no imem_we; cpu_rst = 1. A reload pulse followed by a valid stream then completes with done = 1.
- Reset mid-word: assert rst after 2 bytes of word 0 → all outputs return to reset values immediately. After release, a full valid stream loads correctly and the stale bytes never appear in any write.
- IMEM_LOADER_CHECKSUM_EN:
  - Stream 01 00 93 00 A0 00 33 → done = 1 (0x93^0xA0 = 0x33).
  - Same stream with trailing byte 34 → err = 1; cpu_rst = 1; no FILL writes.
